// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
//
// Purpose:
//   FSM controller for the calculator datapath. It turns debounced button
//   pulses and the mode switches into one-cycle datapath strobes. It handles
//   operand entry, memory read/write, operand capture, ALU result capture and
//   display selection. It also owns the user entry register (keypad_value).
//
//   The datapath memory has a synchronous read, so read data is valid one
//   cycle after 'read'. RD_REQ issues the read and RD_CAP captures the data
//   into op_a or op_b.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   buttons_pressed one-cycle pulses: [0]=enter [1]=inc [2]=dec [3]=clear
//   SWITCHES        mode: 00=store 01=recall 10=add 11=recall
//   keypad_value    current entry value
//   addr_cen        addr register captures keypad_value
//   op_a_cen        op_a captures memory read data
//   op_b_cen        op_b captures memory read data
//   result_cen      result captures op_a + op_b
//   read            memory read of mem[addr]
//   write           memory write to mem[addr]
//   write_sel       write data select: 0=keypad_value, 1=result
//   disp_sel        display select: 0=op_a, 1=result
//   idle            high only in IDLE
// -----------------------------------------------------------------------------
module calc_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       buttons_pressed,
    input  logic [1:0]       SWITCHES,
    output logic [WIDTH-1:0] keypad_value,
    output logic             addr_cen,
    output logic             op_a_cen,
    output logic             op_b_cen,
    output logic             result_cen,
    output logic             read,
    output logic             write,
    output logic             write_sel,
    output logic             disp_sel,
    output logic             idle
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_ENTRY  = 3'd2;
    localparam logic [2:0] S_RD_REQ = 3'd3;
    localparam logic [2:0] S_RD_CAP = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;
    localparam logic [2:0] S_WR     = 3'd6;

    localparam logic [1:0] MODE_STORE = 2'b00;
    localparam logic [1:0] MODE_ADD   = 2'b10;

    localparam logic [WIDTH-1:0] KP_ZERO = '0;
    localparam logic [WIDTH-1:0] KP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [2:0]       state_reg,    state_next;
    logic [WIDTH-1:0] keypad_reg,   keypad_next;
    logic [1:0]       mode_reg,     mode_next;
    logic [1:0]       step_reg,     step_next;
    logic             disp_sel_reg, disp_sel_next;

    // -------------------------------------------------------------------------
    // Button priority resolution: clear > enter > inc > dec.
    // The requests are reordered so that index 0 is the highest priority. A
    // request wins only when no higher-priority request is present in the
    // same cycle, so at most one winner is asserted.
    // -------------------------------------------------------------------------
    logic [3:0] prio_req;
    logic [3:0] prio_win;

    assign prio_req = {buttons_pressed[2],   // dec   (lowest)
                       buttons_pressed[1],   // inc
                       buttons_pressed[0],   // enter
                       buttons_pressed[3]};  // clear (highest)

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_prio
            if (gi == 0) begin : g_top
                assign prio_win[gi] = prio_req[gi];
            end else begin : g_rest
                assign prio_win[gi] = prio_req[gi] & ~(|prio_req[gi-1:0]);
            end
        end
    endgenerate

    logic btn_clear, btn_enter, btn_inc, btn_dec;
    assign btn_clear = prio_win[0];
    assign btn_enter = prio_win[1];
    assign btn_inc   = prio_win[2];
    assign btn_dec   = prio_win[3];

    // -------------------------------------------------------------------------
    // Mode decode from the latched mode. SWITCHES is only sampled on the
    // enter that leaves IDLE, so mid-operation switch changes do not matter.
    // -------------------------------------------------------------------------
    logic mode_store, mode_add, mode_recall;
    assign mode_store  = (mode_reg == MODE_STORE);
    assign mode_add    = (mode_reg == MODE_ADD);
    assign mode_recall = mode_reg[0];   // 01 and 11 are both recall

    logic in_wait;
    assign in_wait = (state_reg == S_IDLE) || (state_reg == S_ENTRY);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        keypad_next   = keypad_reg;
        mode_next     = mode_reg;
        step_next     = step_reg;
        disp_sel_next = disp_sel_reg;

        if (btn_clear) begin
            // Abort from anywhere. Strobes of the current state have already
            // fired. The display selection is intentionally left alone.
            state_next  = S_IDLE;
            keypad_next = KP_ZERO;
            step_next   = 2'd0;
        end else begin
            // Entry edits are allowed only while waiting on the user.
            if (in_wait && btn_inc) begin
                keypad_next = keypad_reg + KP_ONE;
            end else if (in_wait && btn_dec) begin
                keypad_next = keypad_reg - KP_ONE;
            end

            case (state_reg)
                S_IDLE: begin
                    if (btn_enter) begin
                        mode_next  = SWITCHES;
                        step_next  = 2'd0;
                        state_next = S_LATCH;
                    end
                end

                S_LATCH: begin
                    if (mode_store) begin
                        state_next = S_ENTRY;
                    end else if (mode_recall) begin
                        state_next = S_RD_REQ;
                    end else if (step_reg == 2'd2) begin
                        // Both operands are captured and the destination
                        // address is latched, so go compute the sum.
                        state_next = S_EXEC;
                    end else begin
                        state_next = S_RD_REQ;
                    end
                end

                S_ENTRY: begin
                    if (btn_enter) begin
                        // In store mode, enter commits the data value. In add
                        // mode, enter latches the next address.
                        state_next = mode_store ? S_WR : S_LATCH;
                    end
                end

                S_RD_REQ: begin
                    state_next = S_RD_CAP;
                end

                S_RD_CAP: begin
                    if (mode_recall) begin
                        disp_sel_next = 1'b0;
                        state_next    = S_IDLE;
                    end else begin
                        step_next  = step_reg + 2'd1;
                        state_next = S_ENTRY;
                    end
                end

                S_EXEC: begin
                    state_next = S_WR;
                end

                S_WR: begin
                    if (mode_add) begin
                        disp_sel_next = 1'b1;
                    end
                    state_next = S_IDLE;
                end

                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            keypad_reg   <= KP_ZERO;
            mode_reg     <= MODE_STORE;
            step_reg     <= 2'd0;
            disp_sel_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            keypad_reg   <= keypad_next;
            mode_reg     <= mode_next;
            step_reg     <= step_next;
            disp_sel_reg <= disp_sel_next;
        end
    end

    // -------------------------------------------------------------------------
    // Moore outputs. Each strobe is decoded from the state register only.
    // Each strobe-producing state lasts exactly one cycle, so each strobe is
    // a single-cycle pulse. Because reset forces IDLE asynchronously, the
    // strobes drop immediately when reset asserts.
    // -------------------------------------------------------------------------
    assign keypad_value = keypad_reg;
    assign idle         = (state_reg == S_IDLE);
    assign addr_cen     = (state_reg == S_LATCH);
    assign read         = (state_reg == S_RD_REQ);
    assign op_a_cen     = (state_reg == S_RD_CAP) &&
                          (mode_recall || (mode_add && (step_reg == 2'd0)));
    assign op_b_cen     = (state_reg == S_RD_CAP) && mode_add && (step_reg == 2'd1);
    assign result_cen   = (state_reg == S_EXEC);
    assign write        = (state_reg == S_WR);
    assign write_sel    = (state_reg == S_WR) && mode_add;
    assign disp_sel     = disp_sel_reg;

endmodule
